// File: rtl/adc_sample_averager.sv
// Block averager for the delta-ADC result stream: edge-captures each conversion,
// sums 2^LOG2_N of them and presents the truncated mean through a valid/ready holding register.
module adc_sample_averager #(
    parameter int unsigned W      = 16,
    parameter int unsigned LOG2_N = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W-1:0]      sample_i,
    input  logic              sample_strb_i,
    input  logic              clear_i,
    output logic [W-1:0]      avg_o,
    output logic              avg_valid_o,
    input  logic              avg_ready_i,
    output logic              overrun_o,
    output logic [LOG2_N:0]   sample_cnt_o
);

    localparam int unsigned ACC_W = W + LOG2_N;
    localparam int unsigned CNT_W = LOG2_N + 1;
    localparam int unsigned LAST  = (32'd1 << LOG2_N) - 32'd1;

    logic             strb_q,  strb_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [W-1:0]     avg_q,   avg_d;
    logic             valid_q, valid_d;
    logic             ovr_q,   ovr_d;

    logic             take_c;
    logic             load_c;
    logic [ACC_W-1:0] sum_c;

    // Next-state: edge detect, accumulate, and output holding register handshake
    always_comb begin
        strb_d  = sample_strb_i;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        take_c  = sample_strb_i & ~strb_q & ~clear_i;
        load_c  = take_c & (cnt_q == CNT_W'(LAST));
        sum_c   = acc_q + ACC_W'(sample_i);

        if (clear_i) begin
            // avg_q deliberately keeps its last value across a flush
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (take_c) begin
                if (load_c) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = sum_c;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            if (load_c) begin
                avg_d   = W'(sum_c >> LOG2_N);
                valid_d = 1'b1;
                if (valid_q & ~avg_ready_i) begin
                    ovr_d = 1'b1;
                end
            end else if (valid_q & avg_ready_i) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strb_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            strb_q  <= strb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign avg_o        = avg_q;
    assign avg_valid_o  = valid_q;
    assign overrun_o    = ovr_q;
    assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Bench for adc_sample_averager: queue-based block-mean model checked every cycle,
// directed scenarios with literal expectations, then randomized strobes/ready/clear.
module tb_adc_sample_averager;

    localparam int unsigned W      = 16;
    localparam int unsigned LOG2_N = 3;
    localparam int unsigned N      = 1 << LOG2_N;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [W-1:0]      sample_i = '0;
    logic              sample_strb_i = 1'b0;
    logic              clear_i = 1'b0;
    logic [W-1:0]      avg_o;
    logic              avg_valid_o;
    logic              avg_ready_i = 1'b1;
    logic              overrun_o;
    logic [LOG2_N:0]   sample_cnt_o;

    adc_sample_averager #(.W(W), .LOG2_N(LOG2_N)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_i     (sample_i),
        .sample_strb_i(sample_strb_i),
        .clear_i      (clear_i),
        .avg_o        (avg_o),
        .avg_valid_o  (avg_valid_o),
        .avg_ready_i  (avg_ready_i),
        .overrun_o    (overrun_o),
        .sample_cnt_o (sample_cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect the samples of the current block, mean = sum / N
    int          blk[$];
    bit          m_prev  = 1'b0;
    logic [W-1:0] m_avg  = '0;
    bit          m_valid = 1'b0;
    bit          m_ovr   = 1'b0;

    always @(posedge clk or posedge reset) begin : model
        bit     rise;
        bit     done;
        longint s;
        longint mean;
        if (reset) begin
            blk.delete();
            m_prev  = 1'b0;
            m_avg   = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            rise   = sample_strb_i && !m_prev;
            m_prev = sample_strb_i;
            done   = 1'b0;
            mean   = 0;
            if (clear_i) begin
                blk.delete();
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end else begin
                if (rise) begin
                    blk.push_back(int'(sample_i));
                    if (blk.size() == N) begin
                        s = 0;
                        foreach (blk[i]) s += blk[i];
                        mean = s / N;
                        done = 1'b1;
                        blk.delete();
                    end
                end
                if (done) begin
                    if (m_valid && !avg_ready_i) m_ovr = 1'b1;
                    m_valid = 1'b1;
                    m_avg   = W'(mean);
                end else if (m_valid && avg_ready_i) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        chk("avg_o",        64'(avg_o),        64'(m_avg));
        chk("avg_valid_o",  64'(avg_valid_o),  64'(m_valid));
        chk("overrun_o",    64'(overrun_o),    64'(m_ovr));
        chk("sample_cnt_o", 64'(sample_cnt_o), 64'(blk.size()));
    end

    int valid_cycles = 0;
    always @(negedge clk) if (avg_valid_o === 1'b1) valid_cycles++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [W-1:0] v, input int hi, input int lo);
        sample_i      = v;
        sample_strb_i = 1'b1;
        repeat (hi) tick();
        sample_strb_i = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        int v0;
        int iters;

        // Strobe held high through reset release counts once
        sample_i      = W'(5);
        sample_strb_i = 1'b1;
        repeat (3) tick();
        chk("reset_avg", 64'(avg_o), 64'd0);
        chk("reset_cnt", 64'(sample_cnt_o), 64'd0);
        reset = 1'b0;
        tick();
        chk("strb_thru_reset_cnt", 64'(sample_cnt_o), 64'd1);
        repeat (3) tick();
        chk("strb_thru_reset_once", 64'(sample_cnt_o), 64'd1);
        sample_strb_i = 1'b0;
        tick();
        do_clear();

        // Long strobes, ready high: one single-cycle valid pulse of 100
        avg_ready_i = 1'b1;
        v0 = valid_cycles;
        for (int i = 0; i < 8; i++) begin
            strobe(W'(100), 16, 1);
            chk("long_cnt", 64'(sample_cnt_o), 64'((i + 1) % 8));
        end
        tick();
        chk("long_pulse_cycles", 64'(valid_cycles - v0), 64'd1);
        chk("long_avg", 64'(avg_o), 64'd100);

        // Truncating mean and no-wrap at full scale
        for (int i = 0; i < 8; i++) strobe(W'(i), 1, 1);
        chk("trunc_avg", 64'(avg_o), 64'd3);
        for (int i = 0; i < 8; i++) strobe(16'hFFFF, 2, 1);
        chk("fullscale_avg", 64'(avg_o), 64'hFFFF);

        // Overrun with ready held low across two blocks
        do_clear();
        avg_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) strobe(W'(10), 1, 1);
        chk("ovr_first_valid", 64'(avg_valid_o), 64'd1);
        chk("ovr_first_avg", 64'(avg_o), 64'd10);
        chk("ovr_first_flag", 64'(overrun_o), 64'd0);
        for (int i = 0; i < 8; i++) strobe(W'(20), 1, 1);
        chk("ovr_second_avg", 64'(avg_o), 64'd20);
        chk("ovr_second_flag", 64'(overrun_o), 64'd1);
        avg_ready_i = 1'b1;
        tick();
        avg_ready_i = 1'b0;
        chk("ovr_drain_valid", 64'(avg_valid_o), 64'd0);
        tick();
        chk("ovr_sticky", 64'(overrun_o), 64'd1);
        do_clear();
        chk("ovr_cleared", 64'(overrun_o), 64'd0);

        // Completion coincident with accept of the previous mean
        for (int i = 0; i < 8; i++) strobe(W'(10), 1, 1);
        for (int i = 0; i < 7; i++) strobe(W'(30), 1, 1);
        chk("simul_pre_valid", 64'(avg_valid_o), 64'd1);
        sample_i      = W'(30);
        sample_strb_i = 1'b1;
        avg_ready_i   = 1'b1;
        tick();
        avg_ready_i   = 1'b0;
        chk("simul_valid", 64'(avg_valid_o), 64'd1);
        chk("simul_avg", 64'(avg_o), 64'd30);
        chk("simul_ovr", 64'(overrun_o), 64'd0);
        sample_strb_i = 1'b0;
        tick();
        avg_ready_i = 1'b1;
        tick();

        // Asynchronous reset mid-block
        do_clear();
        for (int i = 0; i < 5; i++) strobe(W'(77), 2, 1);
        chk("prereset_cnt", 64'(sample_cnt_o), 64'd5);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_avg", 64'(avg_o), 64'd0);
        chk("async_rst_valid", 64'(avg_valid_o), 64'd0);
        chk("async_rst_cnt", 64'(sample_cnt_o), 64'd0);
        chk("async_rst_ovr", 64'(overrun_o), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) strobe(W'(40), 1, 1);
        chk("post_reset_avg", 64'(avg_o), 64'd40);

        // Clear on a strobe rising edge discards the sample and is not recounted
        avg_ready_i = 1'b0;
        do_clear();
        for (int i = 0; i < 3; i++) strobe(W'(50), 1, 1);
        chk("clr_pre_cnt", 64'(sample_cnt_o), 64'd3);
        sample_i      = W'(999);
        sample_strb_i = 1'b1;
        clear_i       = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr_cnt", 64'(sample_cnt_o), 64'd0);
        repeat (3) tick();
        sample_strb_i = 1'b0;
        tick();
        chk("clr_not_recounted", 64'(sample_cnt_o), 64'd0);
        for (int i = 0; i < 7; i++) strobe(W'(60), 1, 1);
        chk("clr_seven_cnt", 64'(sample_cnt_o), 64'd7);
        chk("clr_seven_valid", 64'(avg_valid_o), 64'd0);
        strobe(W'(60), 1, 1);
        chk("clr_done_valid", 64'(avg_valid_o), 64'd1);
        chk("clr_done_avg", 64'(avg_o), 64'd60);

        // Randomized strobes, ready and occasional flushes against the model
        iters = 400;
        for (int i = 0; i < iters; i++) begin
            avg_ready_i = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 24) == 0) do_clear();
            strobe(W'($urandom), $urandom_range(1, 4), $urandom_range(1, 3));
        end
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
